tt_mask_idx_sequencer: RTL
==========================

// Module: tt_mask_idx_sequencer
// PURPOSE
//  Consumer-side sequencer for the credit-based mask/index channel of the VPU memop path.
//  Buffers 65-bit mask/index items, returns one credit per freed entry, and expands them into a
//  per-element issue stream (element number, byte offset, active bit) for the LSU address generator.
//  Handles unit/strided (64 mask bits per item), indexed (one offset per item) and unmasked unit/strided ops.
// PARAMETERS
//  VLEN          256  max elements per memop; sets counter widths
//  MASK_CREDITS  2    item FIFO depth; equals credits held by producer at reset
// PORTS
//  i_clk                input  1                 clock
//  i_reset_n            input  1                 reset, asynchronous, active-low
//  i_start              input  1                 memop start pulse; sampled only in IDLE
//  i_is_indexed         input  1                 op is indexed (valid with i_start)
//  i_is_masked          input  1                 op is masked (valid with i_start)
//  i_vl                 input  $clog2(VLEN+1)    element count (valid with i_start)
//  i_mask_idx_valid     input  1                 item push
//  i_mask_idx_item      input  65                [64]=mask bit, [63:0]=index or 64 mask bits
//  i_mask_idx_last_idx  input  1                 producer's final item of op
//  o_mask_idx_credit    output 1                 one-cycle credit return pulse
//  o_elem_valid         output 1                 element issue valid
//  i_elem_ready         input  1                 LSU accepts element
//  o_elem_num           output $clog2(VLEN)      element number
//  o_elem_offset        output 64                index offset (0 when not indexed)
//  o_elem_active        output 1                 element enabled by mask
//  o_elem_last          output 1                 element == vl-1
//  o_busy               output 1                 state != IDLE
//  o_done               output 1                 one-cycle completion pulse
//  o_err                output 1                 sticky protocol error; cleared on accepted i_start
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; element counter 0.
//  FSM: IDLE -> ISSUE on i_start && vl!=0; IDLE -> DONE on i_start && vl==0; ISSUE -> DONE on accept
//   of o_elem_last; DONE -> IDLE unconditionally (o_done=1 during DONE). i_start outside IDLE ignored.
//  Latch vl/is_indexed/is_masked on accepted i_start; element counter cleared.
//  FIFO: push on i_mask_idx_valid in any state; push and pop same cycle allowed when full;
//   push while full without pop -> item dropped, o_err set.
//  Issue: o_elem_valid = ISSUE && (FIFO non-empty || (!indexed && !masked)). Outputs combinational
//   from counter + FIFO head; stable while valid && !ready. Accept = valid && ready.
//  Indexed: offset = head[63:0]; active = masked ? head[64] : 1; pop on every accept.
//  Masked non-indexed: active = head[counter[5:0]]; pop on accept when counter[5:0]==63 or last.
//  Unmasked non-indexed: active=1, offset=0, FIFO not consumed.
//  Credit: o_mask_idx_credit registered, asserted cycle after each pop; max one pop per cycle.
//  Checks (set o_err): popped item's last_idx flag != (pop is op's final pop); FIFO non-empty in DONE.
//  Latency: i_start to first o_elem_valid = 1 cycle if head present; head to issue 0 cycles in ISSUE.
//  Counter width $clog2(VLEN); compares against latched vl-1, no wrap (vl<=VLEN).
//  Reset mid-op: all state discarded; producer reset concurrently, restarts with MASK_CREDITS.
// STRUCTURE
//  Package tt_vpu_mask_pkg: state enum {IDLE,ISSUE,DONE}, item field localparams
//   (MASK_BIT=64, IDX_MSB=63), ITEM_W=65, MASK_BITS_PER_ITEM=64.
//  Sub-module tt_credit_fifo (depth MASK_CREDITS, width 66 = item+last flag, registered credit pulse).
//  Top: FSM, element counter, head-bit select, checks.
// TESTING
//  Unmasked strided vl=5, ready=1 -> 5 accepts, elem 0..4, active=1, last on 4, no credits, done 1 cycle later.
//  Masked strided vl=100, items 0xF0F0..F0, 0x...0F (last) -> 100 issues, 2 pops, 2 credit pulses, o_err=0.
//  Indexed masked vl=3, items {1,0x10},{0,0x20},{1,0x30,last} -> offsets 0x10/0x20/0x30, active 1/0/1.
//  Backpressure: ready low 4 cycles mid-op -> outputs unchanged, no pop, no credit until accept.
//  Third push with FIFO full (depth 2), no pop -> item dropped, o_err=1; next i_start clears o_err.
//  vl=0 start -> no o_elem_valid, o_done next cycle; async reset during ISSUE -> outputs 0 immediately.

Source files
------------

// File: rtl/tt_vpu_mask_pkg.sv
// Shared state type and item-field layout for the VPU mask/index memop channel.
// A buffered item carries the 65-bit payload plus the producer's last-item flag on top.
package tt_vpu_mask_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seqState_t;

    localparam int ITEM_W             = 65;
    localparam int MASK_BIT           = 64;
    localparam int IDX_MSB            = 63;
    localparam int MASK_BITS_PER_ITEM = 64;
    localparam int MASK_SEL_W         = $clog2(MASK_BITS_PER_ITEM);
    localparam int LAST_BIT           = ITEM_W;
    localparam int FIFO_W             = ITEM_W + 1;

endpackage

// File: rtl/tt_credit_fifo.sv
// Small item FIFO whose depth equals the producer's credit count; every pop returns one
// credit as a registered single-cycle pulse on the following cycle.
module tt_credit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 66
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_overflow,
    output logic             o_credit
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             credit_q;
    logic             full;
    logic             doPop;
    logic             doPush;

    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign o_empty    = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign doPop      = i_pop && !o_empty;
    assign doPush     = i_push && (!full || doPop);
    assign o_overflow = i_push && full && !doPop;
    assign o_head     = mem_q[rdPtr_q];
    assign o_credit   = credit_q;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= i_push_data;
                wrPtr_q        <= ptrInc(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= ptrInc(rdPtr_q);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!doPush && doPop) begin
                count_q <= count_q - CNT_W'(1);
            end
            credit_q <= doPop;
        end
    end

endmodule

// File: rtl/tt_mask_idx_sequencer.sv
// Consumer-side sequencer for the mask/index channel: buffers items, returns credits and
// expands each memop into a per-element issue stream for the LSU address generator.
module tt_mask_idx_sequencer
    import tt_vpu_mask_pkg::*;
#(
    parameter int VLEN         = 256,
    parameter int MASK_CREDITS = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_start,
    input  logic                       i_is_indexed,
    input  logic                       i_is_masked,
    input  logic [$clog2(VLEN+1)-1:0]  i_vl,
    input  logic                       i_mask_idx_valid,
    input  logic [ITEM_W-1:0]          i_mask_idx_item,
    input  logic                       i_mask_idx_last_idx,
    output logic                       o_mask_idx_credit,
    output logic                       o_elem_valid,
    input  logic                       i_elem_ready,
    output logic [$clog2(VLEN)-1:0]    o_elem_num,
    output logic [63:0]                o_elem_offset,
    output logic                       o_elem_active,
    output logic                       o_elem_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int VL_W  = $clog2(VLEN + 1);
    localparam int CNT_W = $clog2(VLEN);

    seqState_t         state_q;
    logic [CNT_W-1:0]  elemCnt_q;
    logic [VL_W-1:0]   vl_q;
    logic              indexed_q;
    logic              masked_q;
    logic              err_q;

    logic [FIFO_W-1:0] fifoHead;
    logic              fifoEmpty;
    logic              fifoOverflow;
    logic              fifoPop;
    logic              inIssue;
    logic              unmaskedStrided;
    logic              elemValid;
    logic              accept;
    logic              elemLast;
    logic              itemEnd;
    logic              headActive;
    logic              startAccept;
    logic              errSet;

    tt_credit_fifo #(
        .DEPTH (MASK_CREDITS),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (i_mask_idx_valid),
        .i_push_data ({i_mask_idx_last_idx, i_mask_idx_item}),
        .i_pop       (fifoPop),
        .o_head      (fifoHead),
        .o_empty     (fifoEmpty),
        .o_overflow  (fifoOverflow),
        .o_credit    (o_mask_idx_credit)
    );

    // Unmasked unit/strided ops never need an item, so they issue without waiting on the FIFO.
    assign inIssue         = (state_q == ISSUE);
    assign unmaskedStrided = !indexed_q && !masked_q;
    assign elemValid       = inIssue && (!fifoEmpty || unmaskedStrided);
    assign accept          = elemValid && i_elem_ready;
    assign elemLast        = (VL_W'(elemCnt_q) == (vl_q - VL_W'(1)));
    assign itemEnd         = (elemCnt_q[MASK_SEL_W-1:0] == MASK_SEL_W'(MASK_BITS_PER_ITEM - 1));
    assign fifoPop         = accept && (indexed_q || (masked_q && (itemEnd || elemLast)));
    assign startAccept     = (state_q == IDLE) && i_start;

    always_comb begin
        headActive = 1'b1;
        if (masked_q) begin
            headActive = indexed_q ? fifoHead[MASK_BIT] : fifoHead[elemCnt_q[MASK_SEL_W-1:0]];
        end
    end

    // The item closing the op must be exactly the one the producer tagged as last.
    assign errSet = fifoOverflow
                 || (fifoPop && (fifoHead[LAST_BIT] != elemLast))
                 || ((state_q == DONE) && !fifoEmpty);

    assign o_elem_valid  = elemValid;
    assign o_elem_num    = elemCnt_q;
    assign o_elem_offset = (inIssue && indexed_q) ? fifoHead[IDX_MSB:0] : 64'd0;
    assign o_elem_active = inIssue && headActive;
    assign o_elem_last   = inIssue && elemLast;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE);
    assign o_err         = err_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            elemCnt_q <= '0;
            vl_q      <= '0;
            indexed_q <= 1'b0;
            masked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (err_q && !startAccept) || errSet;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        vl_q      <= i_vl;
                        indexed_q <= i_is_indexed;
                        masked_q  <= i_is_masked;
                        elemCnt_q <= '0;
                        state_q   <= (i_vl == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (elemLast) begin
                            state_q <= DONE;
                        end else begin
                            elemCnt_q <= elemCnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
